// File: rtl/seg7_scan_driver.sv
// seg7_scan_driver
// Drives a 4-digit common-anode 7-segment display from four BCD digits.
// The digits are latched once per scan frame so a frame never shows a mix of
// old and new values. Each digit slot starts with an anode-off guard period to
// suppress ghosting. The separator decimal point is steady while paused and
// blinks while running. All outputs are registered and lag the internal scan
// state by one clock.
module seg7_scan_driver #(
    parameter int REFRESH_DIV  = 100000,
    parameter int GUARD        = 4,
    parameter int BLINK_FRAMES = 125
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [3:0] BCD0,
    input  logic [3:0] BCD1,
    input  logic [3:0] BCD2,
    input  logic [3:0] BCD3,
    input  logic       pause,
    input  logic       blank_lz,
    output logic [6:0] seg,
    output logic       dp,
    output logic [3:0] an
);

    localparam int CNT_W = (REFRESH_DIV > 1) ? $clog2(REFRESH_DIV) : 1;
    localparam int FRM_W = (BLINK_FRAMES > 1) ? $clog2(BLINK_FRAMES) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST  = CNT_W'(REFRESH_DIV - 1);
    localparam logic [CNT_W-1:0] CNT_GUARD = CNT_W'(GUARD);
    localparam logic [FRM_W-1:0] FRM_LAST  = FRM_W'(BLINK_FRAMES - 1);

    // Scan state
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [1:0]       idx_q, idx_d;
    logic [FRM_W-1:0] frame_q, frame_d;
    logic             blink_q, blink_d;
    logic             slot_end;
    logic             frame_end;

    // Per-frame digit snapshot, indexed by source input (0 = BCD0 ... 3 = BCD3)
    logic [3:0] bcd_in [4];
    logic [3:0] snap_q [4];

    // Output registers and their next values
    logic [3:0] an_q, an_d;
    logic [6:0] seg_q, seg_d;
    logic       dp_q, dp_d;
    logic [3:0] cur_digit;
    logic       blank_now;

    assign bcd_in[0] = BCD0;
    assign bcd_in[1] = BCD1;
    assign bcd_in[2] = BCD2;
    assign bcd_in[3] = BCD3;

    assign slot_end  = (cnt_q == CNT_LAST);
    assign frame_end = slot_end && (idx_q == 2'd3);

    // Segment patterns, gfedcba, active-low; non-decimal codes show a dash
    function automatic logic [6:0] seg_code(input logic [3:0] d);
        logic [6:0] s;
        case (d)
            4'd0:    s = 7'b1000000;
            4'd1:    s = 7'b1111001;
            4'd2:    s = 7'b0100100;
            4'd3:    s = 7'b0110000;
            4'd4:    s = 7'b0011001;
            4'd5:    s = 7'b0010010;
            4'd6:    s = 7'b0000010;
            4'd7:    s = 7'b1111000;
            4'd8:    s = 7'b0000000;
            4'd9:    s = 7'b0010000;
            default: s = 7'b0111111;
        endcase
        return s;
    endfunction

    // Next-state for slot counter, digit index, frame counter and blink phase
    always_comb begin
        cnt_d   = cnt_q + CNT_W'(1);
        idx_d   = idx_q;
        frame_d = frame_q;
        blink_d = blink_q;
        if (slot_end) begin
            cnt_d = '0;
            idx_d = idx_q + 2'd1;
        end
        if (frame_end) begin
            if (frame_q == FRM_LAST) begin
                frame_d = '0;
                blink_d = ~blink_q;
            end else begin
                frame_d = frame_q + FRM_W'(1);
            end
        end
    end

    // Scan state registers
    always_ff @(posedge clk) begin
        if (reset) begin
            cnt_q   <= '0;
            idx_q   <= '0;
            frame_q <= '0;
            blink_q <= 1'b0;
        end else begin
            cnt_q   <= cnt_d;
            idx_q   <= idx_d;
            frame_q <= frame_d;
            blink_q <= blink_d;
        end
    end

    // One snapshot register per source digit, reloaded only at a frame boundary
    generate
        for (genvar gi = 0; gi < 4; gi++) begin : g_snap
            always_ff @(posedge clk) begin
                if (reset) begin
                    snap_q[gi] <= 4'd0;
                end else if (frame_end) begin
                    snap_q[gi] <= bcd_in[gi];
                end
            end
        end
    endgenerate

    // Slot-to-source mapping: the two minute digits are wired swapped on the
    // board, so slot 2 shows BCD3 and slot 3 shows BCD2
    always_comb begin
        cur_digit = snap_q[0];
        case (idx_q)
            2'd0: cur_digit = snap_q[0];
            2'd1: cur_digit = snap_q[1];
            2'd2: cur_digit = snap_q[3];
            2'd3: cur_digit = snap_q[2];
            default: cur_digit = snap_q[0];
        endcase
    end

    // Output decode: guard interval, leading-zero blank, decimal point
    always_comb begin
        blank_now = (idx_q == 2'd3) && blank_lz && (snap_q[2] == 4'd0);
        seg_d     = seg_code(cur_digit);
        an_d      = 4'b1111;
        if (!(cnt_q < CNT_GUARD) && !blank_now) begin
            an_d = ~(4'b0001 << idx_q);
        end
        dp_d = !((idx_q == 2'd2) && (pause || blink_q));
    end

    // Registered outputs
    always_ff @(posedge clk) begin
        if (reset) begin
            an_q  <= 4'b1111;
            seg_q <= 7'b1111111;
            dp_q  <= 1'b1;
        end else begin
            an_q  <= an_d;
            seg_q <= seg_d;
            dp_q  <= dp_d;
        end
    end

    assign an  = an_q;
    assign seg = seg_q;
    assign dp  = dp_q;

endmodule
